// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave transmitter.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    localparam int TX_FIFO_DEPTH = 4;
    localparam logic [7:0] DEFAULT_FILL_BYTE = 8'h00;

endpackage

// File: rtl/spi_tx_fifo.sv
// Transmit byte buffer: circular FIFO of DEPTH entries (DEPTH = 1 is a holding register).
module spi_tx_fifo #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_q];

    // A push while full is dropped even if a pop happens in the same cycle.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: buffered bytes go out MSB first on miso.
// Define SPI_TX_FIFO_EN for a 4-entry FIFO instead of a single holding register.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = DEFAULT_FILL_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       byte_sent,
    output logic       underrun
);

`ifdef SPI_TX_FIFO_EN
    localparam int BUF_DEPTH = TX_FIFO_DEPTH;
`else
    localparam int BUF_DEPTH = 1;
`endif

    logic sck_meta_q, sck_meta_d;
    logic sck_sync_q, sck_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic cs_meta_q, cs_meta_d;
    logic cs_sync_q, cs_sync_d;
    logic cs_prev_q, cs_prev_d;
    logic sck_rise, sck_fall, cs_fall;

    spi_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;

    logic boundary, load_now;
    logic buf_push, buf_pop, buf_full, buf_empty;
    logic [7:0] buf_dout;

    spi_tx_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (buf_push),
        .pop  (buf_pop),
        .din  (tx_data),
        .dout (buf_dout),
        .full (buf_full),
        .empty(buf_empty)
    );

    assign tx_ready = !buf_full;
    assign buf_push = tx_valid && tx_ready;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_comb begin
        sck_meta_d = sck;
        sck_sync_d = sck_meta_q;
        sck_prev_d = sck_sync_q;
        cs_meta_d  = cs;
        cs_sync_d  = cs_meta_q;
        cs_prev_d  = cs_sync_q;
    end

    assign sck_rise = sck_sync_q && !sck_prev_q;
    assign sck_fall = !sck_sync_q && sck_prev_q;
    assign cs_fall  = !cs_sync_q && cs_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_meta_q <= sck_meta_d;
            sck_sync_q <= sck_sync_d;
            sck_prev_q <= sck_prev_d;
            cs_meta_q  <= cs_meta_d;
            cs_sync_q  <= cs_sync_d;
            cs_prev_q  <= cs_prev_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cs_sync_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A deasserted cs outranks a coincident sck fall, so an abort never pops.
    always_comb begin
        miso_oe   = (state_q != IDLE);
        miso      = miso_oe && shift_q[7];
        boundary  = (state_q == SHIFT) && !cs_sync_q && sck_fall
                    && (cnt_q == 3'd7);
        load_now  = (state_q == LOAD) || boundary;
        buf_pop   = load_now && !buf_empty;
        underrun  = load_now && buf_empty;
        byte_sent = boundary;
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        unique case (state_q)
            SHIFT: begin
                if (cs_sync_q) begin
                    cnt_d = 3'd0;
                end else if (sck_fall) begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: cnt_d = 3'd0;
        endcase
        if (load_now) begin
            shift_d = buf_empty ? FILL_BYTE : buf_dout;
        end else if ((state_q == SHIFT) && !cs_sync_q && sck_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Rising sck only marks the master's sample point; both edges are never seen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(sck_rise && sck_fall));
        end
    end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Testbench for spi_slave_tx: bit-level SPI master with byte-level reference model.
module tb_spi_slave_tx;

    localparam logic [7:0] FILL = 8'h00;
`ifdef SPI_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int HALF = 6;

    typedef struct {
        logic [7:0] val;
        int         nbits;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       miso, miso_oe, tx_ready, byte_sent, underrun;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sent = 0;
    int exp_under = 0;
    int obs_sent = 0;
    int obs_under = 0;

    logic [7:0] model_buf[$];
    exp_t       exp_q[$];
    logic [7:0] rx_sh = 8'h00;
    int         rx_n = 0;

    spi_slave_tx #(
        .FILL_BYTE(FILL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .cs       (cs),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .byte_sent(byte_sent),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic compare_rx(input int n);
        exp_t e;
        logic [7:0] got;
        logic [7:0] want;
        logic [7:0] mask;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_unexpected: got %0d bits, expected none", n);
            return;
        end
        e = exp_q.pop_front();
        mask = 8'hFF;
        mask = mask << (8 - n);
        got = rx_sh << (8 - n);
        want = e.val & mask;
        check("rx_nbits", n, e.nbits);
        check("rx_byte", {24'd0, got}, {24'd0, want});
    endtask

    // Monitor: pulse counters and the master's view of miso.
    always @(negedge clk) begin
        if (byte_sent === 1'b1) obs_sent++;
        if (underrun === 1'b1) obs_under++;
    end

    always @(posedge sck) begin
        if (!cs && rst) begin
            check("miso_oe_at_sample", miso_oe, 1);
            rx_sh = {rx_sh[6:0], miso};
            rx_n++;
            if (rx_n == 8) begin
                compare_rx(8);
                rx_n = 0;
            end
        end
    end

    always @(posedge cs) begin
        if (rx_n > 0) compare_rx(rx_n);
        rx_n = 0;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_load(input bit keep, input int nbits);
        logic [7:0] v;
        if (model_buf.size() > 0) begin
            v = model_buf.pop_front();
        end else begin
            v = FILL;
            exp_under++;
        end
        if (keep) exp_q.push_back('{v, nbits});
    endtask

    task automatic push_byte(input logic [7:0] b);
        int w;
        w = 0;
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && w < 2000) begin
            w++;
            @(negedge clk);
        end
        if (!tx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got tx_ready 0, expected 1");
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_buf.push_back(b);
        #1 tx_valid = 1'b0;
    endtask

    task automatic sck_cycle();
        sck = 1'b1;
        clks(HALF);
        sck = 1'b0;
        clks(HALF);
    endtask

    task automatic transfer(input int nfull, input int k);
        check("idle_miso_oe", miso_oe, 0);
        check("idle_miso", miso, 0);
        cs = 1'b0;
        model_load(nfull > 0 || k > 0, nfull > 0 ? 8 : k);
        clks(8);
        check("tx_ready_after_load", tx_ready, model_buf.size() < DEPTH);
        for (int b = 0; b < nfull; b++) begin
            for (int i = 0; i < 8; i++) begin
                sck = 1'b1;
                clks(HALF);
                sck = 1'b0;
                if (i == 7) model_load(b + 1 < nfull || k > 0, b + 1 < nfull ? 8 : k);
                clks(HALF);
            end
        end
        exp_sent += nfull;
        for (int i = 0; i < k; i++) sck_cycle();
        cs = 1'b1;
        clks(8);
        check("byte_sent_count", obs_sent, exp_sent);
        check("underrun_count", obs_under, exp_under);
        check("tx_ready_idle", tx_ready, model_buf.size() < DEPTH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int np, nf, nk, s;

        clks(3);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_byte_sent", byte_sent, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b1;
        clks(4);

        push_byte(8'hA5);
        transfer(1, 0);

        push_byte(8'h12);
        if (DEPTH > 1) push_byte(8'h34);
        if (DEPTH > 2) push_byte(8'h56);
        if (DEPTH > 3) push_byte(8'h78);
        check("tx_ready_full", tx_ready, 0);
        tx_data = 8'hEE;
        tx_valid = 1'b1;
        clks(3);
        tx_valid = 1'b0;
        transfer(DEPTH, 0);

        transfer(1, 0);

        push_byte(8'hF0);
        transfer(0, 3);
        push_byte(8'h0F);
        transfer(1, 0);

        for (int i = 0; i < DEPTH; i++) push_byte(8'hB0 + 8'(i));
        check("tx_ready_full2", tx_ready, 0);
        fork
            transfer(3, 0);
            begin
                for (int i = 0; i < 3; i++) push_byte(8'hC8 + 8'(i));
            end
        join
        check("tx_ready_after_race", tx_ready, model_buf.size() < DEPTH);

        for (int it = 0; it < 12; it++) begin
            np = $urandom_range(0, DEPTH - model_buf.size());
            for (int i = 0; i < np; i++) push_byte(8'($urandom));
            nf = $urandom_range(0, 3);
            nk = $urandom_range(0, 7);
            transfer(nf, nk);
        end

        s = model_buf.size();
        transfer(s, 0);

        push_byte(8'hC3);
        cs = 1'b0;
        model_load(1, 5);
        clks(8);
        for (int i = 0; i < 5; i++) sck_cycle();
        rst = 1'b0;
        #1;
        check("mid_rst_miso", miso, 0);
        check("mid_rst_miso_oe", miso_oe, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_byte_sent", byte_sent, 0);
        check("mid_rst_underrun", underrun, 0);
        model_buf.delete();
        cs = 1'b1;
        clks(4);
        rst = 1'b1;
        clks(20);
        check("post_rst_idle", miso_oe, 0);
        check("post_rst_under", obs_under, exp_under);

        push_byte(8'h5A);
        transfer(2, 0);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
